// File: rtl/ifft_butterfly_pipe.sv
// Pipelined radix-2 DIF inverse butterfly: (A+B) and (A-B)*conj(W), optionally halved,
// saturated to the input format, with a global-stall valid/ready handshake.
module ifft_butterfly_pipe #(
  parameter int I     = 19,
  parameter int F     = 11,
  parameter int SCALE = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic signed [I+F-1:0] IN1_R,
  input  logic signed [I+F-1:0] IN1_I,
  input  logic signed [I+F-1:0] IN2_R,
  input  logic signed [I+F-1:0] IN2_I,
  input  logic signed [I+F-1:0] W_R,
  input  logic signed [I+F-1:0] W_I,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic signed [I+F-1:0] OUT1_R,
  output logic signed [I+F-1:0] OUT1_I,
  output logic signed [I+F-1:0] OUT2_R,
  output logic signed [I+F-1:0] OUT2_I,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OVF
);

  localparam int DW = I + F;       // sample width
  localparam int SW = DW + 1;      // sum/difference width
  localparam int PW = 2 * DW + 1;  // full-precision product width
  localparam int XW = PW + 1;      // product-sum width

  logic en;

  logic signed [SW-1:0] s_r_d, s_i_d, d_r_d, d_i_d;
  logic signed [SW-1:0] s_r_q, s_i_q, d_r_q, d_i_q;
  logic signed [DW-1:0] w_r_q, w_i_q;

  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic signed [SW-1:0] s2_r_q, s2_i_q;

  logic signed [XW-1:0] x2_r, x2_i;
  logic signed [XW-1:0] o1_r_w, o1_i_w, o2_r_w, o2_i_w;
  logic signed [DW-1:0] out1_r_d, out1_i_d, out2_r_d, out2_i_d;
  logic                 clamp_d;

  logic                 v1_q, v2_q, out_valid_q, ovf_q;
  logic signed [DW-1:0] out1_r_q, out1_i_q, out2_r_q, out2_i_q;

  // The whole pipe advances together; a held output beat freezes every stage.
  assign en       = ~out_valid_q | OUT_READY;
  assign IN_READY = en;

  function automatic logic fits(input logic signed [XW-1:0] v);
    return (&v[XW-1:DW-1]) | ~(|v[XW-1:DW-1]);
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
    if (fits(v)) return v[DW-1:0];
    return v[XW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  // NOTE: always_comb uses blocking assignments and sets every output on every pass,
  // so no latches can be inferred.
  always_comb begin
    s_r_d = SW'(IN1_R) + SW'(IN2_R);
    s_i_d = SW'(IN1_I) + SW'(IN2_I);
    d_r_d = SW'(IN1_R) - SW'(IN2_R);
    d_i_d = SW'(IN1_I) - SW'(IN2_I);
  end

  always_comb begin
    p_rr_d = PW'(d_r_q) * PW'(w_r_q);
    p_ii_d = PW'(d_i_q) * PW'(w_i_q);
    p_ir_d = PW'(d_i_q) * PW'(w_r_q);
    p_ri_d = PW'(d_r_q) * PW'(w_i_q);
  end

  // Conjugate multiply: Re = DrWr + DiWi, Im = DiWr - DrWi; all shifts floor.
  always_comb begin
    x2_r     = XW'(p_rr_q) + XW'(p_ii_q);
    x2_i     = XW'(p_ir_q) - XW'(p_ri_q);
    o1_r_w   = XW'(s2_r_q) >>> SCALE;
    o1_i_w   = XW'(s2_i_q) >>> SCALE;
    o2_r_w   = (x2_r >>> F) >>> SCALE;
    o2_i_w   = (x2_i >>> F) >>> SCALE;
    out1_r_d = sat(o1_r_w);
    out1_i_d = sat(o1_i_w);
    out2_r_d = sat(o2_r_w);
    out2_i_d = sat(o2_i_w);
    clamp_d  = ~(fits(o1_r_w) & fits(o1_i_w) & fits(o2_r_w) & fits(o2_i_w));
  end

  // NOTE: the S1/S2 datapath is left unreset; the reset valid bits qualify its contents.
  always_ff @(posedge CLK) begin
    if (en) begin
      s_r_q  <= s_r_d;
      s_i_q  <= s_i_d;
      d_r_q  <= d_r_d;
      d_i_q  <= d_i_d;
      w_r_q  <= W_R;
      w_i_q  <= W_I;
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ir_q <= p_ir_d;
      p_ri_q <= p_ri_d;
      s2_r_q <= s_r_q;
      s2_i_q <= s_i_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      out1_r_q    <= '0;
      out1_i_q    <= '0;
      out2_r_q    <= '0;
      out2_i_q    <= '0;
    end else if (en) begin
      v1_q        <= IN_VALID;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        out1_r_q <= out1_r_d;
        out1_i_q <= out1_i_d;
        out2_r_q <= out2_r_d;
        out2_i_q <= out2_i_d;
        ovf_q    <= ovf_q | clamp_d;
      end
    end
  end

  assign OUT1_R    = out1_r_q;
  assign OUT1_I    = out1_i_q;
  assign OUT2_R    = out2_r_q;
  assign OUT2_I    = out2_i_q;
  assign OUT_VALID = out_valid_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Bench for ifft_butterfly_pipe: SCALE=0 and SCALE=1 instances share stimulus;
// a longint reference model feeds per-instance scoreboards checked on output handshakes.
module tb_ifft_butterfly_pipe;

  localparam int     DW   = 30;
  localparam int     F    = 11;
  localparam longint MAXV = 536870911;
  localparam longint MINV = -536870912;

  typedef struct packed {
    logic [DW-1:0] o1r, o1i, o2r, o2i;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic signed [DW-1:0] in1_r, in1_i, in2_r, in2_i, w_r, w_i;
  logic in_valid, out_ready;

  logic                 in_ready  [2];
  logic                 out_valid [2];
  logic                 ovf       [2];
  logic signed [DW-1:0] out1_r    [2];
  logic signed [DW-1:0] out1_i    [2];
  logic signed [DW-1:0] out2_r    [2];
  logic signed [DW-1:0] out2_i    [2];

  int   checks   = 0;
  int   failures = 0;
  int   pops  [2];
  logic ovf_m [2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ifft_butterfly_pipe #(.I(19), .F(F), .SCALE(g)) u_dut (
      .CLK(clk), .RST(rst),
      .IN1_R(in1_r), .IN1_I(in1_i), .IN2_R(in2_r), .IN2_I(in2_i),
      .W_R(w_r), .W_I(w_i),
      .IN_VALID(in_valid), .IN_READY(in_ready[g]),
      .OUT1_R(out1_r[g]), .OUT1_I(out1_i[g]), .OUT2_R(out2_r[g]), .OUT2_I(out2_i[g]),
      .OUT_VALID(out_valid[g]), .OUT_READY(out_ready), .OVF(ovf[g])
    );
  end

  function automatic logic [DW-1:0] sat(input longint v, inout logic c);
    if (v > MAXV) begin c = 1'b1; return DW'(MAXV); end
    if (v < MINV) begin c = 1'b1; return DW'(MINV); end
    return DW'(v);
  endfunction

  function automatic exp_t model(input int sc, input logic ovf_in);
    longint ar, ai, br, bi, wr, wi, dr, di, xr, xi;
    logic   c;
    exp_t   e;
    ar = longint'(in1_r); ai = longint'(in1_i);
    br = longint'(in2_r); bi = longint'(in2_i);
    wr = longint'(w_r);   wi = longint'(w_i);
    dr = ar - br;
    di = ai - bi;
    xr = ((dr * wr + di * wi) >>> F) >>> sc;
    xi = ((di * wr - dr * wi) >>> F) >>> sc;
    c = 1'b0;
    e.o1r = sat((ar + br) >>> sc, c);
    e.o1i = sat((ai + bi) >>> sc, c);
    e.o2r = sat(xr, c);
    e.o2i = sat(xi, c);
    e.ovf = ovf_in | c;
    return e;
  endfunction

  task automatic push_beat();
    exp_t e;
    e = model(0, ovf_m[0]); ovf_m[0] = e.ovf; q0.push_back(e);
    e = model(1, ovf_m[1]); ovf_m[1] = e.ovf; q1.push_back(e);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    ovf_m[0] = 1'b0;
    ovf_m[1] = 1'b0;
  endtask

  task automatic drive(input longint ar, ai, br, bi, wr, wi);
    in1_r = DW'(ar); in1_i = DW'(ai);
    in2_r = DW'(br); in2_i = DW'(bi);
    w_r   = DW'(wr); w_i   = DW'(wi);
    in_valid = 1'b1;
  endtask

  // One clock: record an accepted beat at the negedge, return just after the posedge.
  task automatic step(output logic acc);
    @(negedge clk);
    acc = in_valid && in_ready[1] && !rst;
    if (acc) push_beat();
    @(posedge clk); #1;
  endtask

  // Send one beat with OUT_READY high and stop at the negedge after its third edge.
  task automatic send_one(input longint ar, ai, br, bi, wr, wi);
    logic acc;
    out_ready = 1'b1;
    drive(ar, ai, br, bi, wr, wi);
    step(acc);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d/%0d required=0/0", name, q0.size(), q1.size());
    end
  endtask

  // Scoreboard: compare each consumed output beat against the model, in order.
  always @(negedge clk) begin
    exp_t e, got;
    if (!rst && out_ready) begin
      for (int g = 0; g < 2; g++) begin
        if (out_valid[g]) begin
          checks++;
          got = {out1_r[g], out1_i[g], out2_r[g], out2_i[g], ovf[g]};
          if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL sb_unexpected[%0d] got beat o1_r=%0d required no beat", g, out1_r[g]);
          end else begin
            if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
            pops[g]++;
            if (got !== e) begin
              failures++;
              $display("FAIL sb_beat[%0d] got=(%0d,%0d,%0d,%0d,ovf%0b) exp=(%0d,%0d,%0d,%0d,ovf%0b)",
                       g, $signed(got.o1r), $signed(got.o1i), $signed(got.o2r), $signed(got.o2i), got.ovf,
                       $signed(e.o1r), $signed(e.o1i), $signed(e.o2r), $signed(e.o2i), e.ovf);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (out_valid[g] !== 1'b0 || ovf[g] !== 1'b0 || in_ready[g] !== 1'b1) begin
        failures++;
        $display("FAIL reset_ctrl[%0d] got valid=%0b ovf=%0b ready=%0b required 0 0 1",
                 g, out_valid[g], ovf[g], in_ready[g]);
      end
      checks++;
      if ({out1_r[g], out1_i[g], out2_r[g], out2_i[g]} !== '0) begin
        failures++;
        $display("FAIL reset_data[%0d] got=(%0d,%0d,%0d,%0d) required all 0",
                 g, out1_r[g], out1_i[g], out2_r[g], out2_i[g]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    logic acc;
    out_ready = 1'b1;
    drive(6144, 0, 2048, 0, 2048, 0);
    step(acc);
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid[1] !== (k == 3)) begin
        failures++;
        $display("FAIL identity_latency edge%0d got valid=%0b required %0b", k, out_valid[1], (k == 3));
      end
      if (k < 3) begin @(posedge clk); #1; end
    end
    checks++;
    if ({out1_r[1], out1_i[1], out2_r[1], out2_i[1], ovf[1]} !==
        {DW'(4096), DW'(0), DW'(2048), DW'(0), 1'b0}) begin
      failures++;
      $display("FAIL identity_s1 got=(%0d,%0d,%0d,%0d,ovf%0b) required (4096,0,2048,0,ovf0)",
               out1_r[1], out1_i[1], out2_r[1], out2_i[1], ovf[1]);
    end
    checks++;
    if ({out1_r[0], out2_r[0]} !== {DW'(8192), DW'(4096)}) begin
      failures++;
      $display("FAIL identity_s0 got o1_r=%0d o2_r=%0d required 8192 4096", out1_r[0], out2_r[0]);
    end
    @(posedge clk); #1;
    drain("identity");
  endtask

  task automatic test_conjugate();
    send_one(4096, 0, 0, 0, 0, 2048);
    checks++;
    if ({out1_r[1], out1_i[1], out2_r[1], out2_i[1]} !== {DW'(2048), DW'(0), DW'(0), DW'(-2048)}) begin
      failures++;
      $display("FAIL conjugate_s1 got=(%0d,%0d,%0d,%0d) required (2048,0,0,-2048)",
               out1_r[1], out1_i[1], out2_r[1], out2_i[1]);
    end
    checks++;
    if (out2_i[0] !== DW'(-4096)) begin
      failures++;
      $display("FAIL conjugate_s0 got o2_i=%0d required -4096", out2_i[0]);
    end
    @(posedge clk); #1;
    drain("conjugate");
  endtask

  task automatic test_floor();
    send_one(-1, 0, 0, 0, 2048, 0);
    checks++;
    if ({out1_r[1], out2_r[1], out1_r[0], out2_r[0]} !== {DW'(-1), DW'(-1), DW'(-1), DW'(-1)}) begin
      failures++;
      $display("FAIL floor got s1=(%0d,%0d) s0=(%0d,%0d) required all -1",
               out1_r[1], out2_r[1], out1_r[0], out2_r[0]);
    end
    @(posedge clk); #1;
    drain("floor");
  endtask

  task automatic test_saturation();
    send_one(MAXV, MINV, MAXV, MINV, 2048, 0);
    checks++;
    if ({out1_r[0], out1_i[0], ovf[0]} !== {DW'(MAXV), DW'(MINV), 1'b1}) begin
      failures++;
      $display("FAIL sat_s0 got=(%0d,%0d,ovf%0b) required (%0d,%0d,ovf1)",
               out1_r[0], out1_i[0], ovf[0], MAXV, MINV);
    end
    checks++;
    if (ovf[1] !== 1'b0) begin
      failures++;
      $display("FAIL sat_s1_ovf got=%0b required 0", ovf[1]);
    end
    @(posedge clk); #1;
    send_one(6144, 0, 2048, 0, 2048, 0);
    checks++;
    if (ovf[0] !== 1'b1 || out1_r[0] !== DW'(8192)) begin
      failures++;
      $display("FAIL sat_sticky got ovf=%0b o1_r=%0d required ovf=1 o1_r=8192", ovf[0], out1_r[0]);
    end
    @(posedge clk); #1;
    drain("saturation");
  endtask

  task automatic test_backpressure();
    int   n = 0, p1 = pops[1], low_seen = 0;
    logic stalled_prev = 1'b0, exp_rdy;
    logic signed [DW-1:0] hold_val = '0;
    for (int cyc = 0; cyc < 200 && n < 16; cyc++) begin
      drive(longint'(n) * 2048, 0, 0, 0, 2048, 0);
      out_ready = !(cyc >= 5 && cyc <= 9);
      @(negedge clk);
      exp_rdy = !(out_valid[1] && !out_ready);
      checks++;
      if (in_ready[1] !== exp_rdy) begin
        failures++;
        $display("FAIL bp_in_ready cyc%0d got=%0b required=%0b", cyc, in_ready[1], exp_rdy);
      end
      if (stalled_prev) begin
        checks++;
        if (out_valid[1] !== 1'b1 || out1_r[1] !== hold_val) begin
          failures++;
          $display("FAIL bp_hold cyc%0d got valid=%0b o1_r=%0d required 1 %0d",
                   cyc, out_valid[1], out1_r[1], hold_val);
        end
      end
      stalled_prev = out_valid[1] && !out_ready;
      hold_val     = out1_r[1];
      if (!in_ready[1]) low_seen++;
      if (in_ready[1]) begin push_beat(); n++; end
      @(posedge clk); #1;
    end
    drain("backpressure");
    checks++;
    if (n != 16 || pops[1] - p1 != 16 || low_seen == 0) begin
      failures++;
      $display("FAIL bp_count got sent=%0d recv=%0d stalls=%0d required 16 16 >0", n, pops[1] - p1, low_seen);
    end
  endtask

  task automatic test_reset_midstream();
    logic acc;
    int   n = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1024 * (k + 1), 0, 0, 0, 2048, 0);
      step(acc);
      if (acc) n++;
    end
    checks++;
    if (n != 3 || out_valid[1] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_fill got accepted=%0d valid=%0b required 3 1", n, out_valid[1]);
    end
    rst = 1'b1; in_valid = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0 || out_valid[1] !== 1'b0 || ovf[0] !== 1'b0 || in_ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_after got valid=%0b/%0b ovf0=%0b ready=%0b required 0/0 0 1",
               out_valid[0], out_valid[1], ovf[0], in_ready[1]);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid[1] !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_flushed cyc%0d got valid=%0b required 0", k, out_valid[1]);
      end
      @(posedge clk); #1;
    end
    send_one(10240, -2048, 2048, 2048, 2048, 0);
    checks++;
    if ({out_valid[1], out1_r[1], out1_i[1], out2_r[1], out2_i[1]} !==
        {1'b1, DW'(6144), DW'(0), DW'(4096), DW'(-2048)}) begin
      failures++;
      $display("FAIL rstmid_next got valid=%0b (%0d,%0d,%0d,%0d) required 1 (6144,0,4096,-2048)",
               out_valid[1], out1_r[1], out1_i[1], out2_r[1], out2_i[1]);
    end
    @(posedge clk); #1;
    drain("rstmid");
  endtask

  task automatic test_back_to_back();
    int sent = 0, p0 = pops[0], p1 = pops[1];
    for (int cyc = 0; cyc < 400 && sent < 40; cyc++) begin
      in1_r = DW'($urandom); in1_i = DW'($urandom);
      in2_r = DW'($urandom); in2_i = DW'($urandom);
      w_r   = DW'($urandom); w_i   = DW'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (in_ready[1] !== (!out_valid[1] || out_ready)) begin
        failures++;
        $display("FAIL b2b_in_ready cyc%0d got=%0b required=%0b", cyc, in_ready[1], !out_valid[1] || out_ready);
      end
      if (in_valid && in_ready[1]) begin push_beat(); sent++; end
      @(posedge clk); #1;
    end
    drain("b2b");
    checks++;
    if (sent != 40 || pops[0] - p0 != 40 || pops[1] - p1 != 40) begin
      failures++;
      $display("FAIL b2b_count got sent=%0d recv=%0d/%0d required 40 40/40", sent, pops[0] - p0, pops[1] - p1);
    end
  endtask

  initial begin
    pops[0] = 0;
    pops[1] = 0;
    test_reset();
    test_identity();
    test_conjugate();
    test_floor();
    test_saturation();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
